// File: rtl/hilo_mul.sv
// Iterative signed multiplier (MULT) with the HI/LO register pair, MTHI/MTLO writes,
// MFHI/MFLO read port and a pipeline stall while a multiply is in flight.
module hilo_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mulCtr,
  input  logic [1:0]       regToMul,
  input  logic             mulToReg,
  input  logic             mulRead,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mulOut,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic             r_neg;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_start;
  logic             w_last;
  logic             w_wr_lo;
  logic             w_wr_hi;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_acc_nxt;
  logic [PW-1:0]    w_result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (mulCtr) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode; MT writes and starts are only honoured in IDLE, mulCtr wins a conflict
  always_comb begin
    busy    = (r_state == S_RUN);
    stall   = busy & (mulCtr | mulToReg | (regToMul != 2'b00));
    w_start = !busy & mulCtr;
    w_last  = busy & (r_cnt == LAST_CNT);
    w_wr_lo = !busy & !mulCtr & (regToMul == 2'b01);
    w_wr_hi = !busy & !mulCtr & (regToMul == 2'b10);
  end

  // Magnitudes; |most-negative| maps onto itself as an unsigned value
  assign w_abs_a = a[WIDTH-1] ? WIDTH'(-a) : a;
  assign w_abs_b = b[WIDTH-1] ? WIDTH'(-b) : b;

  // One shift-add step: add into the upper half with carry, then shift {carry, acc} right
  assign w_sum     = {1'b0, r_acc[PW-1:WIDTH]} + {1'b0, (r_mb[0] ? r_ma : {WIDTH{1'b0}})};
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
  assign w_result  = r_neg ? PW'(-w_acc_nxt) : w_acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ma  <= '0;
      r_mb  <= '0;
      r_neg <= 1'b0;
      r_acc <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_start) begin
        r_ma  <= w_abs_a;
        r_mb  <= w_abs_b;
        r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
        r_acc <= '0;
        r_cnt <= '0;
      end else if (busy) begin
        r_acc <= w_acc_nxt;
        r_mb  <= r_mb >> 1;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_hi <= w_result[PW-1:WIDTH];
        r_lo <= w_result[WIDTH-1:0];
      end
      if (w_wr_lo) r_lo <= a;
      if (w_wr_hi) r_hi <= a;
    end
  end

  assign mulOut = mulRead ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_mul.sv
// Directed bench for hilo_mul: multiply results, busy/stall timing, MT/MF access and reset abort.
module tb_hilo_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        mulCtr;
  logic [1:0]  regToMul;
  logic        mulToReg;
  logic        mulRead;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] mulOut;
  logic        busy;
  logic        stall;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hilo_mul #(.WIDTH(32)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .mulCtr   (mulCtr),
    .regToMul (regToMul),
    .mulToReg (mulToReg),
    .mulRead  (mulRead),
    .a        (a),
    .b        (b),
    .mulOut   (mulOut),
    .busy     (busy),
    .stall    (stall)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reads {HI,LO} through the combinational port, called just after a falling edge
  task automatic read_hilo(output logic [63:0] v);
    mulRead = 1'b1;
    #1 v[63:32] = mulOut;
    mulRead = 1'b0;
    #1 v[31:0] = mulOut;
  endtask

  // Presents a start for one edge (E0); returns at the falling edge after E0
  task automatic start_mult(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] rtm);
    @(negedge clk);
    mulCtr   = 1'b1;
    regToMul = rtm;
    a        = va;
    b        = vb;
    @(posedge clk);
    @(negedge clk);
    mulCtr   = 1'b0;
    regToMul = 2'b00;
  endtask

  // Counts busy cycles, bounded; returns at the first falling edge with busy low
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mult(input string tag, input logic [31:0] va, input logic [31:0] vb,
                      input logic [1:0] rtm, input logic [63:0] exp);
    int          n;
    logic [63:0] v;
    start_mult(va, vb, rtm);
    wait_done(n);
    chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
    read_hilo(v);
    chk({tag, "_hilo"}, v, exp);
  endtask

  initial begin
    int          n;
    int          n_stall;
    int          n_leak;
    logic [63:0] v;

    rst = 1'b1; mulCtr = 1'b0; regToMul = 2'b00; mulToReg = 1'b0; mulRead = 1'b0;
    a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    read_hilo(v);
    chk("rst_hilo", v, 64'd0);
    rst = 1'b0;

    mult("m3x5", 32'd3, 32'd5, 2'b11, 64'h0000_0000_0000_000F);
    mult("mneg2x3", 32'hFFFF_FFFE, 32'd3, 2'b11, 64'hFFFF_FFFF_FFFF_FFFA);
    mult("mmin_sq", 32'h8000_0000, 32'h8000_0000, 2'b11, 64'h4000_0000_0000_0000);

    // Operand-select code without a start leaves HI/LO alone
    @(negedge clk);
    regToMul = 2'b11; a = 32'hAAAA_5555;
    @(negedge clk);
    regToMul = 2'b00;
    chk("rtm11_busy", 64'(busy), 64'd0);
    read_hilo(v);
    chk("rtm11_hilo", v, 64'h4000_0000_0000_0000);

    // MFLO held during RUN: stalls every busy cycle, old LO visible, new LO after E32
    start_mult(32'd7, 32'd9, 2'b11);
    mulToReg = 1'b1; mulRead = 1'b0;
    n = 0; n_stall = 0; n_leak = 0;
    while (busy && n < 40) begin
      n++;
      if (stall) n_stall++;
      if (mulOut !== 32'h0) n_leak++;
      @(negedge clk);
    end
    chk("mflo_busy_cycles", 64'(n), 64'd32);
    chk("mflo_stall_cycles", 64'(n_stall), 64'd32);
    chk("mflo_no_partial", 64'(n_leak), 64'd0);
    #1;
    chk("mflo_stall_after", 64'(stall), 64'd0);
    chk("mflo_value", 64'(mulOut), 64'h3F);
    mulToReg = 1'b0;

    // MTHI held during RUN is written at E33
    start_mult(32'd7, 32'd9, 2'b11);
    regToMul = 2'b10; a = 32'h0000_1234;
    #1 chk("mthi_stall", 64'(stall), 64'd1);
    wait_done(n);
    chk("mthi_busy_cycles", 64'(n), 64'd32);
    #1 chk("mthi_stall_after", 64'(stall), 64'd0);
    mulRead = 1'b1;
    #1 chk("mthi_hi_before", 64'(mulOut), 64'd0);
    @(negedge clk);
    regToMul = 2'b00;
    read_hilo(v);
    chk("mthi_hilo", v, 64'h0000_1234_0000_003F);

    // MTLO then MTHI; same-cycle read sees the old value
    @(negedge clk);
    regToMul = 2'b01; a = 32'hDEAD_BEEF; mulRead = 1'b0;
    #1 chk("mtlo_no_bypass", 64'(mulOut), 64'h3F);
    @(negedge clk);
    regToMul = 2'b10; a = 32'h0000_0001;
    @(negedge clk);
    regToMul = 2'b00;
    read_hilo(v);
    chk("mt_hilo", v, 64'h0000_0001_DEAD_BEEF);

    // Start and MTLO together: start wins, LO not written from a
    mult("conflict", 32'd6, 32'hFFFF_FFFD, 2'b01, 64'hFFFF_FFFF_FFFF_FFEE);

    // Reset sampled at E10 aborts the multiply
    @(negedge clk);
    regToMul = 2'b01; a = 32'h0000_0055;
    @(negedge clk);
    regToMul = 2'b00;
    start_mult(32'd3, 32'd5, 2'b11);
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    read_hilo(v);
    chk("abort_hilo", v, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    read_hilo(v);
    chk("abort_no_write", v, 64'd0);
    mult("after_abort", 32'd3, 32'd5, 2'b11, 64'h0000_0000_0000_000F);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_mul.md
# hilo_mul

Sequential signed multiplier and HI/LO register pair driven by the multiply-control decode signals (`mulCtr`, `regToMul`, `mulToReg`, `mulRead`). It executes MULT over 32 iterative cycles, services MTHI/MTLO writes and MFHI/MFLO reads, and raises a stall toward the pipeline while a multiply is in flight. It sits in the execute stage, next to the ALU, and its read port feeds the register-file write-back mux.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits, and the product is 2×`WIDTH`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mulCtr` input 1: start a signed multiply (MULT).
- `regToMul` input 2: 01 = write LO from `a`; 10 = write HI from `a`; 11 = MULT operand select, no effect unless `mulCtr` is set; 00 = none.
- `mulToReg` input 1: the current instruction reads HI/LO (MFHI/MFLO).
- `mulRead` input 1: read select; 1 = HI, 0 = LO.
- `a` input WIDTH: rs operand; the multiplicand, and the MTHI/MTLO data.
- `b` input WIDTH: rt operand; the multiplier.
- `mulOut` output WIDTH: combinational read data; `mulRead ? HI : LO`.
- `busy` output 1: a multiply is in progress.
- `stall` output 1: the pipeline must hold the current instruction.

## Operation
- States: IDLE and RUN, plus a 5-bit iteration counter `cnt`.
- IDLE, `mulCtr`=1:
  - Latch `ma`=|a| and `mb`=|b| as unsigned WIDTH-bit values; |−2^31| = 0x80000000 is legal.
  - Latch `neg` = a[31]^b[31].
  - Clear the 64-bit accumulator `acc` and set `cnt`=0.
  - Go to RUN.
- RUN, each cycle:
  - If mb[0]=1, `acc[63:32] += ma`, with the carry kept in a 33-bit intermediate.
  - Shift the {carry, acc, mb} combination right by 1 (standard shift-add).
  - Increment `cnt`.
- RUN, final cycle (`cnt`=31):
  - Write {HI,LO} ← `neg` ? −acc_final : acc_final, using two's complement over 64 bits.
  - Return to IDLE.
- HI/LO hold their value throughout RUN; intermediate results are never visible on `mulOut`.
- MTLO/MTHI (`regToMul` 01/10) in IDLE: LO/HI ← `a` at the edge. A write to one register leaves the other unchanged.
- `regToMul`=11 with `mulCtr`=0: no effect.
- `stall` = `busy` & (`mulCtr` | `mulToReg` | `regToMul`≠00).
  - While stalled, no start and no MT write is accepted; the request stays on the inputs and is accepted in the first IDLE cycle.
  - Unrelated instructions do not stall during RUN.
- `mulCtr` and `regToMul`∈{01,10} never coincide (exclusive decode). If they do, `mulCtr` wins and the MT write is dropped.
- Reset:
  - HI=0, LO=0, state=IDLE, `busy`=0, `stall`=0, `cnt`=0.
  - `mulOut` then reads 0.
  - Reset during RUN aborts the multiply, with no partial write.

## Timing
- A start sampled at rising edge E0 enters RUN. `busy`=1 from just after E0 until just after E32.
- HI/LO are updated at E32. `busy` falls at E32.
- An MFHI/MFLO stalled during RUN reads the new value in the cycle after E32; its `stall` is low in that cycle.
- Back-to-back MULT: the second start is accepted at E32+1 at the earliest.
- An MT write takes effect at the edge it is sampled in IDLE. A read in the same cycle returns the old value, with no bypass.
- `mulOut` is combinational from HI/LO and `mulRead`, with zero latency.

## Test plan
- After reset: `busy`=0, `stall`=0, `mulOut`=0 for both `mulRead` values.
- MULT a=3, b=5 → `busy` high for exactly 32 cycles; then HI=0x00000000, LO=0x0000000F.
- MULT a=0xFFFFFFFE (−2), b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULT a=b=0x80000000 → HI=0x40000000, LO=0x00000000.
- MULT 7×9, then MFLO held on the inputs from E1:
  - `stall`=1 through E31.
  - `mulOut`=0x3F with `stall`=0 in the cycle after E32.
  - A repeat with MTHI a=0x1234 held from E1 ends with HI=0x1234 written at E33 and LO=0x3F unchanged.
- MTLO 0xDEADBEEF, then MTHI 0x1 → MFLO reads 0xDEADBEEF and MFHI reads 0x1.
- Assert `rst` at E10 of MULT 3×5 → after reset HI=LO=0 and `busy`=0; a fresh MULT then completes normally.
